// File: rtl/led_arbiter.sv
// Round-robin arbiter that gives one of NREQ sources the 4-bit LED bank, with a minimum
// tenure before preemption and a one-cycle blank gap on every ownership change.
module led_arbiter #(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned HOLD_CYCLES  = 1000,
  parameter logic [3:0]  IDLE_PATTERN = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              owner_valid,
  output logic [1:0]        owner,
  output logic [3:0]        leds
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      leds_q, leds_d;

  logic            win_valid;
  logic [1:0]      win_idx;
  logic [3:0]      owner_data;
  logic            owner_req;
  logic            contender;
  logic            expired;

  // Search pointer+1 .. pointer+NREQ (mod NREQ); the last owner is considered last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    for (int off = 1; off <= int'(NREQ); off++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!win_valid && req[i] && (i == (int'(ptr_q) + off) % int'(NREQ))) begin
          win_valid = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    owner_data = IDLE_PATTERN;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner_q == 2'(i)) begin
        owner_data = data[4*i +: 4];
      end
    end
  end

  assign owner_req = |(req & gnt_q);
  assign contender = |(req & ~gnt_q);
  assign expired   = (cnt_q == HoldMax);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    leds_d  = IDLE_PATTERN;

    case (state_q)
      StIdle, StGap: begin
        gnt_d   = '0;
        state_d = StIdle;
        if (win_valid) begin
          state_d = StOwn;
          owner_d = win_idx;
          ptr_d   = win_idx;
          cnt_d   = '0;
          for (int i = 0; i < int'(NREQ); i++) begin
            gnt_d[i] = (win_idx == 2'(i));
          end
        end
      end
      StOwn: begin
        // Voluntary release and expiry with a contender both end in the same gap.
        if (!owner_req || (expired && contender)) begin
          state_d = StGap;
          gnt_d   = '0;
        end else begin
          leds_d = owner_data;
          if (!expired) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= 2'd0;
      ptr_q   <= 2'(NREQ - 1);
      cnt_q   <= '0;
      leds_q  <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
    end
  end

  assign gnt         = gnt_q;
  assign owner_valid = |gnt_q;
  assign owner       = owner_q;
  assign leds        = leds_q;

  gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with NREQ=3, HOLD_CYCLES=4, IDLE_PATTERN=0000.
module tb_led_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [11:0] data = '0;
  logic [2:0]  gnt;
  logic        owner_valid;
  logic [1:0]  owner;
  logic [3:0]  leds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_arbiter #(
    .NREQ        (3),
    .HOLD_CYCLES (4),
    .IDLE_PATTERN(4'b0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data       (data),
    .gnt        (gnt),
    .owner_valid(owner_valid),
    .owner      (owner),
    .leds       (leds)
  );

  // Status vector layout: {gnt[2:0], owner_valid, owner[1:0], leds[3:0]}
  function automatic logic [9:0] st(logic [2:0] g, logic v, logic [1:0] o, logic [3:0] l);
    return {g, v, o, l};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    data  = 12'hfff;
    step();
    step();
    checks++;
    if ({gnt, owner_valid, owner, leds} !== st(3'b000, 1'b0, 2'd0, 4'b0000)) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", {gnt, owner_valid, owner, leds},
               st(3'b000, 1'b0, 2'd0, 4'b0000));
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gnt, owner_valid, owner, leds} !== st(3'b000, 1'b0, 2'd0, 4'b0000)) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: got %b required %b", i,
                 {gnt, owner_valid, owner, leds}, st(3'b000, 1'b0, 2'd0, 4'b0000));
      end
    end
  endtask

  task automatic test_single_grant();
    logic [2:0]  rq[6];
    logic [11:0] dt[6];
    logic [9:0]  ex[6];
    rq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    dt = '{12'h00a, 12'h00a, 12'h005, 12'hf05, 12'hf05, 12'hf05};
    ex = '{st(3'b001, 1'b1, 2'd0, 4'b0000), st(3'b001, 1'b1, 2'd0, 4'b1010),
           st(3'b001, 1'b1, 2'd0, 4'b0101), st(3'b001, 1'b1, 2'd0, 4'b0101),
           st(3'b000, 1'b0, 2'd0, 4'b0000), st(3'b000, 1'b0, 2'd0, 4'b0000)};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      req  = rq[i];
      data = dt[i];
      step();
      checks++;
      if ({gnt, owner_valid, owner, leds} !== ex[i]) begin
        errors++;
        $display("FAIL single_grant step %0d: got %b required %b", i,
                 {gnt, owner_valid, owner, leds}, ex[i]);
      end
    end
  endtask

  task automatic test_preemption();
    int         seq[4];
    logic [3:0] lv[4];
    logic [9:0] exp_v;
    seq = '{0, 1, 2, 0};
    lv  = '{4'h1, 4'h2, 4'h4, 4'h1};
    apply_reset();
    data = 12'h421;
    req  = 3'b111;
    step();
    for (int r = 0; r < 4; r++) begin
      for (int t = 0; t < 5; t++) begin
        exp_v = st(3'(1 << seq[r]), 1'b1, 2'(seq[r]), (t == 0) ? 4'h0 : lv[r]);
        checks++;
        if ({gnt, owner_valid, owner, leds} !== exp_v) begin
          errors++;
          $display("FAIL preempt owner %0d tenure %0d: got %b required %b", seq[r], t,
                   {gnt, owner_valid, owner, leds}, exp_v);
        end
        step();
      end
      exp_v = st(3'b000, 1'b0, 2'(seq[r]), 4'h0);
      checks++;
      if ({gnt, owner_valid, owner, leds} !== exp_v) begin
        errors++;
        $display("FAIL preempt gap after owner %0d: got %b required %b", seq[r],
                 {gnt, owner_valid, owner, leds}, exp_v);
      end
      if (r < 3) step();
    end
    req = '0;
  endtask

  task automatic test_early_release();
    logic [2:0] rq[12];
    logic [9:0] ex[12];
    rq = '{3'b110, 3'b110, 3'b110, 3'b100, 3'b110, 3'b110,
           3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110};
    ex = '{st(3'b010, 1'b1, 2'd1, 4'h0), st(3'b010, 1'b1, 2'd1, 4'h6),
           st(3'b010, 1'b1, 2'd1, 4'h6), st(3'b000, 1'b0, 2'd1, 4'h0),
           st(3'b100, 1'b1, 2'd2, 4'h0), st(3'b100, 1'b1, 2'd2, 4'h3),
           st(3'b100, 1'b1, 2'd2, 4'h3), st(3'b100, 1'b1, 2'd2, 4'h3),
           st(3'b100, 1'b1, 2'd2, 4'h3), st(3'b000, 1'b0, 2'd2, 4'h0),
           st(3'b010, 1'b1, 2'd1, 4'h0), st(3'b010, 1'b1, 2'd1, 4'h6)};
    apply_reset();
    data = 12'h369;
    for (int i = 0; i < 12; i++) begin
      req = rq[i];
      step();
      checks++;
      if ({gnt, owner_valid, owner, leds} !== ex[i]) begin
        errors++;
        $display("FAIL early_release step %0d: got %b required %b", i,
                 {gnt, owner_valid, owner, leds}, ex[i]);
      end
    end
    req = '0;
  endtask

  task automatic test_release_at_expiry();
    logic [2:0] rq[8];
    logic [9:0] ex[8];
    rq = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b010, 3'b010, 3'b010};
    ex = '{st(3'b001, 1'b1, 2'd0, 4'h0), st(3'b001, 1'b1, 2'd0, 4'h5),
           st(3'b001, 1'b1, 2'd0, 4'h5), st(3'b001, 1'b1, 2'd0, 4'h5),
           st(3'b001, 1'b1, 2'd0, 4'h5), st(3'b000, 1'b0, 2'd0, 4'h0),
           st(3'b010, 1'b1, 2'd1, 4'h0), st(3'b010, 1'b1, 2'd1, 4'hc)};
    apply_reset();
    data = 12'h0c5;
    for (int i = 0; i < 8; i++) begin
      req = rq[i];
      step();
      checks++;
      if ({gnt, owner_valid, owner, leds} !== ex[i]) begin
        errors++;
        $display("FAIL release_at_expiry step %0d: got %b required %b", i,
                 {gnt, owner_valid, owner, leds}, ex[i]);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_tenure();
    logic [2:0] rq[6];
    logic       rs[6];
    logic [9:0] ex[6];
    rq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b110, 3'b110};
    rs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ex = '{st(3'b100, 1'b1, 2'd2, 4'h0), st(3'b100, 1'b1, 2'd2, 4'hf),
           st(3'b100, 1'b1, 2'd2, 4'hf), st(3'b000, 1'b0, 2'd0, 4'h0),
           st(3'b010, 1'b1, 2'd1, 4'h0), st(3'b010, 1'b1, 2'd1, 4'h7)};
    apply_reset();
    data = 12'hf70;
    for (int i = 0; i < 6; i++) begin
      req   = rq[i];
      reset = rs[i];
      step();
      checks++;
      if ({gnt, owner_valid, owner, leds} !== ex[i]) begin
        errors++;
        $display("FAIL reset_mid_tenure step %0d: got %b required %b", i,
                 {gnt, owner_valid, owner, leds}, ex[i]);
      end
    end
    reset = 1'b0;
    req   = '0;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_preemption();
    test_early_release();
    test_release_at_expiry();
    test_reset_mid_tenure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Shares the board's 4-bit LED bank among up to four on-chip requesters (switch echo, counters, test patterns) so that exactly one source drives the LEDs at any time. Round-robin arbitration, one-hot grant, minimum-tenure timer before preemption, and a one-cycle blank gap on every ownership change. Sits between the LED-producing blocks and the top-level `leds[3:0]` pins; requester 0 is conventionally the direct switch echo.

## Interface
- `NREQ`, 3: number of requesters, legal range 2..4.
- `HOLD_CYCLES`, 1000: minimum cycles an owner keeps the LEDs before a waiting requester can preempt it; must be ≥1.
- `IDLE_PATTERN`, 4'b0000: LED value when no one owns the bank and during the gap cycle.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NREQ: request per source; held high for as long as the source wants the LEDs.
- `data`  in  4*NREQ: LED value per source; source i drives `data[4*i+3:4*i]`.
- `gnt`  out  NREQ: one-hot grant, registered; all-zero when unowned.
- `owner_valid`  out  1: high when `gnt` is non-zero.
- `owner`  out  2: index of the current owner; holds its last value when `owner_valid` is low.
- `leds`  out  4: registered LED drive.

## Operation
- FSM states: IDLE, OWN, GAP.
- IDLE: `gnt`=0, `leds`=IDLE_PATTERN. On any `req` high → OWN with the arbitration winner.
- OWN: `gnt` one-hot at owner, `leds` <= owner's `data` slice every cycle. Tenure counter clears on entry, increments each OWN cycle, saturates at HOLD_CYCLES. Width is clog2(HOLD_CYCLES+1).
- OWN → GAP when either condition holds:
  - owner's `req` is sampled low (voluntary release, honored immediately regardless of tenure), or
  - tenure == HOLD_CYCLES and any other `req` is high (preemption).
  - Both in the same cycle → GAP; identical behavior.
- GAP lasts exactly one cycle: `gnt`=0, `owner_valid`=0, `leds`=IDLE_PATTERN. At its end, arbitrate: any `req` → OWN, else → IDLE.
- Arbitration is round-robin. The pointer holds the last owner. Search order is pointer+1, pointer+2, …, wrapping modulo NREQ, and the pointer itself is searched last. The pointer updates to the winner on every grant.
- An owner that keeps `req` high with no contenders keeps the LEDs indefinitely; the counter sits saturated.
- `req` bits at index ≥ NREQ do not exist. `data` is ignored for non-owners.

## Timing
- Reset (sampled at an edge) → after that edge: state IDLE, `gnt`=0, `owner_valid`=0, `owner`=0, `leds`=IDLE_PATTERN, pointer=NREQ-1 (so req0 wins first), counter=0. This takes priority over all other activity, including mid-tenure.
- Grant latency: `req` sampled high at edge k in IDLE → `gnt`/`owner_valid` high after edge k. `leds` shows the owner's data as sampled at edge k+1, i.e. one cycle after the grant.
- Data latency in OWN: `data` change → `leds` change after the next edge (1 cycle).
- Release latency: owner `req` sampled low at edge k → `gnt`=0 and `leds`=IDLE_PATTERN after edge k. The next grant, if any, appears after edge k+1.
- Preemption: tenure reaches HOLD_CYCLES after HOLD_CYCLES OWN edges. With a contender present, the owner is held for at least HOLD_CYCLES cycles, and the handover costs exactly one gap cycle.
- `gnt` never has more than one bit set. `gnt` never changes between two owners without an intervening all-zero cycle.

## Test plan
All scenarios use NREQ=3, HOLD_CYCLES=4, IDLE_PATTERN=0000.
- Reset then idle: `reset` high 2 cycles, `req`=000 → `gnt`=000, `owner_valid`=0, `leds`=0000 held.
- Single grant: `req`=001, `data[3:0]`=1010 → `gnt`=001 one cycle after the sampling edge, `leds`=1010 one cycle later. Change data to 0101 → `leds`=0101 after 1 edge.
- Preemption with round-robin: `req`=111 from idle → owner 0. After 4 OWN cycles → 1 gap cycle, then owner 1. After 4 more → owner 2, then owner 0. Check `gnt` stays one-hot and gap cycles show `leds`=0000.
- Early release: owner 1 drops `req` after 2 cycles while `req[2]`=1 → gap cycle → `gnt`=100 with no tenure wait. Previous owner 1 re-requesting is served after 2.
- Simultaneous release and expiry: owner 0 drops `req` on the exact cycle tenure hits 4 while `req[1]`=1 → single gap cycle, then `gnt`=010.
- Reset mid-tenure: `reset` asserted while owner 2 holds with `leds`=1111 → after that edge all outputs at reset values. A following `req`=110 grants owner 1 first, since the pointer is back at 2.
